// File: rtl/w21_layer_seq.sv
// -----------------------------------------------------------------------------
// w21_layer_seq
// Sequencer and multiply-accumulate controller for the layer-2 fully-connected
// stage. For each of N_COL weight columns it sweeps the row address 0..DEPTH-1,
// multiplies every signed weight by the matching activation, and accumulates
// the products. It then scales the column sum by an arithmetic right shift,
// saturates it to OUT_W bits, and offers it downstream over a valid/ready
// handshake.
//
// Ports:
//   clk, rst    rising-edge clock, asynchronous active-high reset
//   start       begin a layer pass (sampled only while idle)
//   abort       synchronous return to idle from any active state
//   adrs_clm    row address shared by all weight ROMs
//   col_sel     selects which ROM column drives w_in
//   w_in        selected weight (combinational ROM read, same cycle)
//   act_addr    activation buffer read address (always equals adrs_clm)
//   act_in      activation (combinational read, same cycle, Q3.12)
//   busy        high whenever the sequencer is not idle
//   out_valid   column result available
//   out_ready   downstream accepts the result
//   out_data    scaled, saturated column result
//   out_col     column index of out_data
//   out_sat     out_data was clipped
//   done        one-cycle pulse after the last column is accepted
// -----------------------------------------------------------------------------
module w21_layer_seq #(
  parameter int DEPTH  = 300,
  parameter int ADDR_W = 9,
  parameter int N_COL  = 8,
  parameter int COL_W  = 3,
  parameter int W_W    = 21,
  parameter int ACT_W  = 16,
  parameter int ACC_W  = 48,
  parameter int SHIFT  = 12,
  parameter int OUT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] adrs_clm,
  output logic [COL_W-1:0]  col_sel,
  input  logic [W_W-1:0]    w_in,
  output logic [ADDR_W-1:0] act_addr,
  input  logic [ACT_W-1:0]  act_in,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [COL_W-1:0]  out_col,
  output logic              out_sat,
  output logic              done
);

  localparam int PROD_W = W_W + ACT_W;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(N_COL - 1);

  // Saturation bounds expressed at accumulator width; SAT_MIN is the
  // bitwise complement of SAT_MAX (0..01..1 -> 1..10..0).
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN1,
    S_DRAIN2,
    S_OUT,
    S_DONE
  } state_t;

  state_t                    r_state;
  state_t                    w_next_state;
  logic [ADDR_W-1:0]         r_addr;
  logic [COL_W-1:0]          r_col;
  logic signed [PROD_W-1:0]  r_prod;
  logic                      r_prod_vld;
  logic signed [ACC_W-1:0]   r_acc;
  logic [OUT_W-1:0]          r_out_data;
  logic [COL_W-1:0]          r_out_col;
  logic                      r_out_sat;

  logic signed [PROD_W-1:0]  w_w_ext;
  logic signed [PROD_W-1:0]  w_act_ext;
  logic signed [PROD_W-1:0]  w_prod;
  logic signed [ACC_W-1:0]   w_prod_ext;
  logic signed [ACC_W-1:0]   w_scaled;
  logic [OUT_W-1:0]          w_sat_data;
  logic                      w_sat;
  logic                      w_abort;
  logic                      w_accept;

  // Operands are widened to the full product width first so the multiply is
  // evaluated at 37 bits with no silent truncation.
  assign w_w_ext    = {{ACT_W{w_in[W_W-1]}}, w_in};
  assign w_act_ext  = {{W_W{act_in[ACT_W-1]}}, act_in};
  assign w_prod     = w_w_ext * w_act_ext;
  assign w_prod_ext = {{(ACC_W - PROD_W){r_prod[PROD_W-1]}}, r_prod};
  assign w_scaled   = r_acc >>> SHIFT;

  // abort only acts outside IDLE and wins over a same-cycle handshake.
  assign w_abort  = abort && (r_state != S_IDLE);
  assign w_accept = (r_state == S_OUT) && out_ready && !w_abort;

  // NOTE: every signal assigned in an always_comb block gets a default first,
  // so no path through the case/if tree can leave it unassigned and infer a latch.
  always_comb begin
    w_sat_data = w_scaled[OUT_W-1:0];
    w_sat      = 1'b0;
    if (w_scaled > SAT_MAX) begin
      w_sat_data = {1'b0, {(OUT_W - 1){1'b1}}};
      w_sat      = 1'b1;
    end else if (w_scaled < SAT_MIN) begin
      w_sat_data = {1'b1, {(OUT_W - 1){1'b0}}};
      w_sat      = 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next_state = S_RUN;
      S_RUN:    if (r_addr == LAST_ADDR) w_next_state = S_DRAIN1;
      S_DRAIN1: w_next_state = S_DRAIN2;
      S_DRAIN2: w_next_state = S_OUT;
      S_OUT:    if (w_accept) w_next_state = (r_col == LAST_COL) ? S_DONE : S_RUN;
      S_DONE:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
    if (w_abort) w_next_state = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values and later statements in this block
  // (abort, column advance) cleanly override earlier ones for the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr     <= '0;
      r_col      <= '0;
      r_prod     <= '0;
      r_prod_vld <= 1'b0;
      r_acc      <= '0;
      r_out_data <= '0;
      r_out_col  <= '0;
      r_out_sat  <= 1'b0;
    end else begin
      // The product register is one stage behind the address, so the add
      // lags by a cycle; DRAIN1 absorbs the final product.
      if (r_prod_vld) r_acc <= r_acc + w_prod_ext;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr     <= '0;
            r_col      <= '0;
            r_acc      <= '0;
            r_prod_vld <= 1'b0;
          end
        end
        S_RUN: begin
          r_prod     <= w_prod;
          r_prod_vld <= 1'b1;
          if (r_addr != LAST_ADDR) r_addr <= r_addr + 1'b1;
        end
        S_DRAIN1: r_prod_vld <= 1'b0;
        S_DRAIN2: begin
          r_out_data <= w_sat_data;
          r_out_sat  <= w_sat;
          r_out_col  <= r_col;
        end
        S_OUT: begin
          if (w_accept && (r_col != LAST_COL)) begin
            r_col  <= r_col + 1'b1;
            r_addr <= '0;
            r_acc  <= '0;
          end
        end
        S_DONE: begin
          r_addr <= '0;
          r_col  <= '0;
        end
        default: ;
      endcase

      if (w_abort) begin
        r_addr     <= '0;
        r_col      <= '0;
        r_acc      <= '0;
        r_prod_vld <= 1'b0;
      end
    end
  end

  assign adrs_clm  = r_addr;
  assign act_addr  = r_addr;
  assign col_sel   = r_col;
  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_OUT);
  assign done      = (r_state == S_DONE);
  assign out_data  = r_out_data;
  assign out_col   = r_out_col;
  assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_w21_layer_seq.sv
// -----------------------------------------------------------------------------
// tb_w21_layer_seq
// Directed bench for w21_layer_seq. A behavioural weight ROM / activation
// buffer answers the DUT's addresses combinationally. Each table entry selects
// a ROM pattern and carries hand-computed per-column results; a full layer
// pass is run per entry. Hand-written sequences cover async reset and abort.
// -----------------------------------------------------------------------------
module tb_w21_layer_seq;

  logic               clk;
  logic               rst;
  logic               start;
  logic               abort;
  logic [8:0]         adrs_clm;
  logic [2:0]         col_sel;
  logic signed [20:0] w_in;
  logic [8:0]         act_addr;
  logic signed [15:0] act_in;
  logic               busy;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;
  logic [2:0]         out_col;
  logic               out_sat;
  logic               done;

  int n_checks = 0;
  int n_pass   = 0;
  int mode     = 0;

  typedef struct {
    int           mode;
    int           bp_col;     // column held in OUT for 5 cycles (-1: none)
    int           start_col;  // column where start is pulsed at addr 77 (-1: none)
    logic [127:0] exp_data;   // column c result in bits [16*c +: 16]
    logic [7:0]   exp_sat;
  } vec_t;

  vec_t vecs[6];

  w21_layer_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .adrs_clm  (adrs_clm),
    .col_sel   (col_sel),
    .w_in      (w_in),
    .act_addr  (act_addr),
    .act_in    (act_in),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_col   (out_col),
    .out_sat   (out_sat),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Weight ROM model: mode picks the pattern, c the column, a the row.
  function automatic logic signed [20:0] rom_w(input int m, input int c, input int a);
    case (m)
      0: return 21'(c + 1);
      1: return 21'sd1048575;
      2: return 21'h100000;
      3: return (a % 2 == 1) ? -21'sd1 : 21'sd1;
      default: begin
        case (c)
          0, 3:    return (a == 0) ? 21'sd4096 : 21'sd0;
          1, 4:    return (a == 0) ? 21'sd4096 : ((a == 1) ? 21'sd1 : 21'sd0);
          2:       return (a == 0) ? -21'sd4096 : 21'sd0;
          5:       return -21'sd1;
          6:       return (a == 0) ? -21'sd1 : 21'sd0;
          default: return (a == 0) ? 21'sd1 : 21'sd0;
        endcase
      end
    endcase
  endfunction

  function automatic logic signed [15:0] rom_act(input int m, input int c, input int a);
    if (a < 0 || a > 299) return 16'sd0;
    case (m)
      0, 3: return 16'sd4096;
      1, 2: return 16'sd32767;
      default: begin
        case (c)
          0, 1, 2: return 16'sd32767;
          3, 4:    return 16'h8000;
          5:       return 16'sd4096;
          6:       return 16'sd1;
          default: return 16'sd4095;
        endcase
      end
    endcase
  endfunction

  always_comb begin
    w_in   = rom_w(mode, int'(col_sel), int'(adrs_clm));
    act_in = rom_act(mode, int'(col_sel), int'(act_addr));
  end

  task automatic check(input string name, input longint actual, input longint expected);
    n_checks++;
    if (actual != expected)
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    else
      n_pass++;
  endtask

  // One complete layer pass starting from IDLE; inputs change and outputs are
  // sampled on the falling edge.
  task automatic run_pass(input vec_t v);
    int errs;
    logic signed [15:0] exp_d;
    mode = v.mode;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;        // first RUN cycle (T)
    for (int c = 0; c < 8; c++) begin
      exp_d = $signed(v.exp_data[16*c +: 16]);
      errs = 0;
      for (int k = 0; k < 300; k++) begin
        if (adrs_clm != 9'(k) || act_addr != adrs_clm || col_sel != 3'(c) ||
            !busy || out_valid || done) errs++;
        start = (c == v.start_col && k == 77);
        @(negedge clk);
      end
      start = 1'b0;
      check($sformatf("m%0d c%0d sweep", v.mode, c), errs, 0);
      errs = 0;
      for (int d = 0; d < 2; d++) begin
        if (out_valid) errs++;
        @(negedge clk);
      end
      if (!out_valid) errs++;            // cycle T+302
      check($sformatf("m%0d c%0d valid_latency", v.mode, c), errs, 0);
      check($sformatf("m%0d c%0d out_data", v.mode, c), out_data, exp_d);
      check($sformatf("m%0d c%0d out_sat", v.mode, c), out_sat, v.exp_sat[c]);
      check($sformatf("m%0d c%0d out_col", v.mode, c), out_col, c);
      if (c == v.bp_col) begin
        errs = 0;
        for (int h = 0; h < 5; h++) begin
          @(negedge clk);
          if (!out_valid || out_data != exp_d || out_col != 3'(c) ||
              out_sat != v.exp_sat[c] || adrs_clm != 9'd299) errs++;
        end
        check($sformatf("m%0d c%0d backpressure", v.mode, c), errs, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check($sformatf("m%0d c%0d valid_drop", v.mode, c), out_valid, 0);
    end
    check($sformatf("m%0d done_pulse", v.mode), {done, busy}, 2'b11);
    @(negedge clk);
    check($sformatf("m%0d idle_after_done", v.mode), {done, busy}, 2'b00);
  endtask

  task automatic start_and_run(input int cycles);
    mode = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   errs;

    vecs[0] = '{mode: 0, bp_col: 2, start_col: -1,
                exp_data: {16'sd2400, 16'sd2100, 16'sd1800, 16'sd1500,
                           16'sd1200, 16'sd900, 16'sd600, 16'sd300},
                exp_sat: 8'h00};
    vecs[1] = '{mode: 1, bp_col: -1, start_col: -1,
                exp_data: {8{16'h7FFF}}, exp_sat: 8'hFF};
    vecs[2] = '{mode: 2, bp_col: -1, start_col: -1,
                exp_data: {8{16'h8000}}, exp_sat: 8'hFF};
    vecs[3] = '{mode: 3, bp_col: -1, start_col: -1,
                exp_data: 128'd0, exp_sat: 8'h00};
    vecs[4] = '{mode: 4, bp_col: -1, start_col: -1,
                exp_data: {16'sd0, -16'sd1, -16'sd300, 16'h8000,
                           16'h8000, -16'sd32767, 16'h7FFF, 16'h7FFF},
                exp_sat: 8'b0001_0010};
    vecs[5] = '{mode: 0, bp_col: -1, start_col: 3,
                exp_data: vecs[0].exp_data, exp_sat: 8'h00};

    rst = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("reset_state",
          {adrs_clm, act_addr, col_sel, out_data, out_col, out_sat, out_valid, done, busy}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_pass(vecs[i]);

    // Asynchronous reset in the middle of column 0.
    start_and_run(150);
    check("pre_rst_addr", adrs_clm, 150);
    #1 rst = 1'b1;
    #1;
    check("rst_async",
          {adrs_clm, act_addr, col_sel, out_data, out_col, out_sat, out_valid, done, busy}, 0);
    @(negedge clk);
    rst = 1'b0;
    v = vecs[0];
    v.bp_col = -1;
    run_pass(v);

    // abort mid-RUN: back to idle with no done pulse.
    start_and_run(150);
    check("pre_abort_addr", adrs_clm, 150);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle", {busy, out_valid, adrs_clm, col_sel}, 0);
    errs = 0;
    for (int d = 0; d < 3; d++) begin
      if (done || busy) errs++;
      @(negedge clk);
    end
    check("abort_no_done", errs, 0);
    run_pass(v);

    // abort coinciding with the handshake of column 0 wins.
    start_and_run(302);
    check("abort_hs_valid", out_valid, 1);
    abort = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    out_ready = 1'b0;
    check("abort_hs_idle", {busy, done, out_valid, adrs_clm, col_sel}, 0);
    @(negedge clk);
    check("abort_hs_no_done", {busy, done}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
